seq_divider: RTL and testbench

- Parametrised multi-cycle unsigned integer divider; successor to the fixed divide-by-two block.
- Takes an arbitrary N-bit dividend and divisor and produces quotient and remainder via restoring shift-subtract, one quotient bit per clock.
- Uses a start/busy/done handshake so it can be driven by a controller FSM or a testbench loop.
- Flags divide-by-zero instead of producing garbage.

---
 rtl/seq_divider.sv | 106 ++++++++++
 tb/tb_seq_divider.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, start/busy/done
// handshake, divide-by-zero reported through a flag instead of garbage results.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] p_next;
  logic [WIDTH-1:0] a_next;

  // One restoring step; the trial value is WIDTH+1 bits so divisors with the MSB set work.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] p_in,
                                                  input logic [WIDTH-1:0] a_in,
                                                  input logic [WIDTH-1:0] d_in);
    logic [WIDTH:0] t;
    logic [WIDTH:0] diff;
    t    = {p_in, a_in[WIDTH-1]};
    diff = t - {1'b0, d_in};
    if (t >= {1'b0, d_in})
      return {diff[WIDTH-1:0], a_in[WIDTH-2:0], 1'b1};
    else
      return {t[WIDTH-1:0], a_in[WIDTH-2:0], 1'b0};
  endfunction

  always_comb begin
    {p_next, a_next} = div_step(p, a, d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      a           <= '0;
      p           <= '0;
      d           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            d           <= divisor;
            cnt         <= '0;
            p           <= '0;
            a           <= dividend;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          p   <= p_next;
          a   <= a_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state     <= DONE;
            done      <= 1'b1;
            quotient  <= a_next;
            remainder <= p_next;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: an 8-bit instance for handshake, edge cases and a sweep,
// plus a 16-bit instance for the wide-latency case.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  dividend = '0;
  logic [7:0]  divisor = '0;
  logic        busy, done, div_by_zero;
  logic [7:0]  quotient, remainder;

  logic        start16 = 1'b0;
  logic [15:0] dividend16 = '0;
  logic [15:0] divisor16 = '0;
  logic        busy16, done16, div_by_zero16;
  logic [15:0] quotient16, remainder16;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  seq_divider #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .dividend(dividend16), .divisor(divisor16),
    .busy(busy16), .done(done16), .quotient(quotient16), .remainder(remainder16),
    .div_by_zero(div_by_zero16)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one 8-bit division; returns at the negedge where done is seen.
  task automatic run8(input logic [7:0] dvd, input logic [7:0] dvs,
                      output logic [7:0] q, output logic [7:0] r, output logic z,
                      output int lat);
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) chk("done_timeout", 32'(lat), 32'd0);
    q = quotient;
    r = remainder;
    z = div_by_zero;
  endtask

  logic [7:0] q, r;
  logic       z;
  int         lat;
  int         ndone;

  typedef struct {
    logic [7:0] dvd;
    logic [7:0] dvs;
    logic [7:0] eq;
    logic [7:0] er;
  } vec_t;

  vec_t edge_vecs[5] = '{
    '{8'd255, 8'd1,   8'd255, 8'd0},
    '{8'd255, 8'd255, 8'd1,   8'd0},
    '{8'd0,   8'd13,  8'd0,   8'd0},
    '{8'd128, 8'd200, 8'd0,   8'd128},
    '{8'd254, 8'd2,   8'd127, 8'd0}
  };

  logic [7:0] sweep_dvs[6] = '{8'd1, 8'd2, 8'd3, 8'd7, 8'd128, 8'd255};

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", 32'(quotient), 32'd0);
    chk("rst_r", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    reset = 1'b0;

    // 200/7 with latency and hold
    run8(8'd200, 8'd7, q, r, z, lat);
    chk("200/7_lat", 32'(lat), 32'd8);
    chk("200/7_q", 32'(q), 32'd28);
    chk("200/7_r", 32'(r), 32'd4);
    chk("200/7_dbz", 32'(z), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_done", 32'(done), 32'd0);
      chk("hold_busy", 32'(busy), 32'd0);
      chk("hold_q", 32'(quotient), 32'd28);
      chk("hold_r", 32'(remainder), 32'd4);
    end

    // Edge cases
    foreach (edge_vecs[i]) begin
      run8(edge_vecs[i].dvd, edge_vecs[i].dvs, q, r, z, lat);
      chk("edge_q", 32'(q), 32'(edge_vecs[i].eq));
      chk("edge_r", 32'(r), 32'(edge_vecs[i].er));
      chk("edge_lat", 32'(lat), 32'd8);
    end

    // Divide by zero, then recovery
    run8(8'd5, 8'd0, q, r, z, lat);
    chk("dbz_lat", 32'(lat), 32'd0);
    chk("dbz_q", 32'(q), 32'd255);
    chk("dbz_r", 32'(r), 32'd5);
    chk("dbz_flag", 32'(z), 32'd1);
    @(negedge clk);
    chk("dbz_done_single", 32'(done), 32'd0);
    run8(8'd9, 8'd3, q, r, z, lat);
    chk("9/3_q", 32'(q), 32'd3);
    chk("9/3_r", 32'(r), 32'd0);
    chk("9/3_dbz", 32'(z), 32'd0);

    // Starts while busy are ignored
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd9;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    lat   = 0;
    repeat (2) begin
      @(negedge clk);
      lat++;
    end
    dividend = 8'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    @(negedge clk);
    lat++;
    start = 1'b0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("ign_lat", 32'(lat), 32'd8);
    if (done) ndone++;
    chk("ign_q", 32'(quotient), 32'd11);
    chk("ign_r", 32'(remainder), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign_busy_after", 32'(busy), 32'd0);
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("ign_done_count", 32'(ndone), 32'd1);
    chk("ign_q_hold", 32'(quotient), 32'd11);

    // Reset mid-operation
    @(negedge clk);
    dividend = 8'd77;
    divisor  = 8'd4;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_q", 32'(quotient), 32'd0);
    chk("abort_r", 32'(remainder), 32'd0);
    chk("abort_dbz", 32'(div_by_zero), 32'd0);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    run8(8'd77, 8'd4, q, r, z, lat);
    chk("77/4_q", 32'(q), 32'd19);
    chk("77/4_r", 32'(r), 32'd1);

    // 16-bit instance
    @(negedge clk);
    dividend16 = 16'd65535;
    divisor16  = 16'd256;
    start16    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0;
    lat = 0;
    while (!done16 && lat < 60) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk("w16_lat", 32'(lat), 32'd16);
    chk("w16_q", 32'(quotient16), 32'd255);
    chk("w16_r", 32'(remainder16), 32'd255);
    chk("w16_dbz", 32'(div_by_zero16), 32'd0);

    // Sweep of all dividends against a divisor set
    begin
      bit stop_sweep;
      stop_sweep = 1'b0;
      foreach (sweep_dvs[k]) begin
        for (int n = 0; n < 256; n++) begin
          if (n_errors >= 5) stop_sweep = 1'b1;
          if (stop_sweep) break;
          run8(8'(n), sweep_dvs[k], q, r, z, lat);
          chk("sweep_q", 32'(q), 32'(n) / 32'(sweep_dvs[k]));
          chk("sweep_r", 32'(r), 32'(n) % 32'(sweep_dvs[k]));
        end
        if (stop_sweep) break;
      end
    end

    if (n_errors == 0) $display("TEST PASSED.");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
